sm_reg_scan_ctrl: RTL and testbench

Sequencer and arbiter for the core's register-file debug read port (`regAddr`/`regData`), placed between board-level inputs and `sm_top`. In manual mode it passes the switch-selected address through. In scan mode it walks a register range automatically, waits a settle time, captures each value and holds it for a programmable dwell. The captured value and its address drive the seven-segment display path.

---
 rtl/sm_reg_scan_ctrl.sv | 159 +++++++++++++++
 tb/tb_sm_reg_scan_ctrl.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/sm_reg_scan_ctrl.sv
// Debug read-port sequencer: passes a manual address through, or walks a register
// range, lets each read settle, captures the value and holds it for the display.
module sm_reg_scan_ctrl #(
  parameter int unsigned        SETTLE    = 2,
  parameter int unsigned        DWELL_W   = 24,
  parameter logic [DWELL_W-1:0] DWELL     = 24'd5000000,
  parameter logic [4:0]         REG_FIRST = 5'd0,
  parameter logic [4:0]         REG_LAST  = 5'd31
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        scan_en,
  input  logic        hold,
  input  logic        step,
  input  logic [4:0]  man_addr,
  input  logic [31:0] reg_data_in,
  output logic [4:0]  reg_addr,
  output logic [31:0] disp_data,
  output logic [4:0]  disp_addr,
  output logic        disp_valid,
  output logic        wrap,
  output logic        scan_active
);

  typedef enum logic [1:0] {
    ST_MANUAL,
    ST_SETUP,
    ST_CAPTURE,
    ST_DWELL
  } state_t;

  localparam logic [3:0]         SETTLE_LOAD = 4'(SETTLE);
  localparam logic [DWELL_W-1:0] DWELL_ONE   = {{(DWELL_W-1){1'b0}}, 1'b1};
  localparam logic [DWELL_W-1:0] DWELL_LOAD  = DWELL - DWELL_ONE;

  state_t             r_state;
  logic [4:0]         r_reg_addr;
  logic [31:0]        r_disp_data;
  logic [4:0]         r_disp_addr;
  logic               r_disp_valid;
  logic               r_wrap;
  logic [3:0]         r_settle_cnt;
  logic [DWELL_W-1:0] r_dwell_cnt;

  state_t             w_state_next;
  logic [4:0]         w_reg_addr_next;
  logic [31:0]        w_disp_data_next;
  logic [4:0]         w_disp_addr_next;
  logic               w_disp_valid_next;
  logic               w_wrap_next;
  logic [3:0]         w_settle_cnt_next;
  logic [DWELL_W-1:0] w_dwell_cnt_next;
  logic               w_advance;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_MANUAL;
      r_reg_addr   <= 5'd0;
      r_disp_data  <= 32'd0;
      r_disp_addr  <= 5'd0;
      r_disp_valid <= 1'b0;
      r_wrap       <= 1'b0;
      r_settle_cnt <= 4'd0;
      r_dwell_cnt  <= '0;
    end else begin
      r_state      <= w_state_next;
      r_reg_addr   <= w_reg_addr_next;
      r_disp_data  <= w_disp_data_next;
      r_disp_addr  <= w_disp_addr_next;
      r_disp_valid <= w_disp_valid_next;
      r_wrap       <= w_wrap_next;
      r_settle_cnt <= w_settle_cnt_next;
      r_dwell_cnt  <= w_dwell_cnt_next;
    end
  end

  always_comb begin
    w_state_next      = r_state;
    w_reg_addr_next   = r_reg_addr;
    w_disp_data_next  = r_disp_data;
    w_disp_addr_next  = r_disp_addr;
    w_disp_valid_next = 1'b0;
    w_wrap_next       = 1'b0;
    w_settle_cnt_next = r_settle_cnt;
    w_dwell_cnt_next  = r_dwell_cnt;
    w_advance         = 1'b0;

    case (r_state)
      ST_MANUAL: begin
        w_reg_addr_next  = man_addr;
        w_disp_data_next = reg_data_in;
        w_disp_addr_next = r_reg_addr;
        if (scan_en) begin
          w_state_next      = ST_SETUP;
          w_reg_addr_next   = REG_FIRST;
          w_settle_cnt_next = SETTLE_LOAD;
        end
      end
      ST_SETUP: begin
        if (r_settle_cnt == 4'd0) begin
          w_state_next = ST_CAPTURE;
        end else begin
          w_settle_cnt_next = r_settle_cnt - 4'd1;
        end
      end
      ST_CAPTURE: begin
        w_disp_data_next  = reg_data_in;
        w_disp_addr_next  = r_reg_addr;
        w_disp_valid_next = 1'b1;
        w_dwell_cnt_next  = DWELL_LOAD;
        w_state_next      = ST_DWELL;
      end
      ST_DWELL: begin
        // step outranks hold so an operator can single-step a frozen scan
        if (step) begin
          w_advance = 1'b1;
        end else if (hold) begin
          w_dwell_cnt_next = r_dwell_cnt;
        end else if (r_dwell_cnt == '0) begin
          w_advance = 1'b1;
        end else begin
          w_dwell_cnt_next = r_dwell_cnt - DWELL_ONE;
        end
      end
      default: begin
        w_state_next = ST_MANUAL;
      end
    endcase

    if (w_advance) begin
      if (r_reg_addr == REG_LAST) begin
        w_reg_addr_next = REG_FIRST;
        w_wrap_next     = 1'b1;
      end else begin
        w_reg_addr_next = r_reg_addr + 5'd1;
      end
      w_settle_cnt_next = SETTLE_LOAD;
      w_state_next      = ST_SETUP;
    end

    // Leaving scan mode behaves like a MANUAL cycle; a pending capture is dropped.
    if ((r_state != ST_MANUAL) && !scan_en) begin
      w_state_next      = ST_MANUAL;
      w_reg_addr_next   = man_addr;
      w_disp_data_next  = reg_data_in;
      w_disp_addr_next  = r_reg_addr;
      w_disp_valid_next = 1'b0;
      w_wrap_next       = 1'b0;
    end
  end

  assign reg_addr    = r_reg_addr;
  assign disp_data   = r_disp_data;
  assign disp_addr   = r_disp_addr;
  assign disp_valid  = r_disp_valid;
  assign wrap        = r_wrap;
  assign scan_active = (r_state != ST_MANUAL);

endmodule

// File: tb/tb_sm_reg_scan_ctrl.sv
// Directed bench for sm_reg_scan_ctrl: SETTLE=2, DWELL=4, scan range 0..3.
module tb_sm_reg_scan_ctrl;

  logic        clk;
  logic        rst;
  logic        scan_en;
  logic        hold;
  logic        step;
  logic [4:0]  man_addr;
  logic [31:0] reg_data_in;
  logic [4:0]  reg_addr;
  logic [31:0] disp_data;
  logic [4:0]  disp_addr;
  logic        disp_valid;
  logic        wrap;
  logic        scan_active;

  logic [31:0] regs [32];
  int          n_checks;
  int          n_errors;
  int          k;

  sm_reg_scan_ctrl #(
    .SETTLE    (2),
    .DWELL_W   (24),
    .DWELL     (24'd4),
    .REG_FIRST (5'd0),
    .REG_LAST  (5'd3)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .scan_en     (scan_en),
    .hold        (hold),
    .step        (step),
    .man_addr    (man_addr),
    .reg_data_in (reg_data_in),
    .reg_addr    (reg_addr),
    .disp_data   (disp_data),
    .disp_addr   (disp_addr),
    .disp_valid  (disp_valid),
    .wrap        (wrap),
    .scan_active (scan_active)
  );

  assign reg_data_in = regs[reg_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, k);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
    k++;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_reg_addr"}, 32'(reg_addr), 32'd0);
    chk({tag, "_disp_data"}, disp_data, 32'd0);
    chk({tag, "_disp_addr"}, 32'(disp_addr), 32'd0);
    chk({tag, "_disp_valid"}, 32'(disp_valid), 32'd0);
    chk({tag, "_wrap"}, 32'(wrap), 32'd0);
    chk({tag, "_scan_active"}, 32'(scan_active), 32'd0);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    k        = 0;
    for (int i = 0; i < 32; i++) regs[i] = 32'h100 + 32'(i);
    for (int i = 0; i < 4; i++) regs[i] = 32'hA0 + 32'(i);
    regs[5] = 32'h1234;
    rst      = 1'b1;
    scan_en  = 1'b0;
    hold     = 1'b0;
    step     = 1'b0;
    man_addr = 5'd0;

    // Reset for two cycles, then manual pass-through of address 5
    @(negedge clk);
    @(negedge clk);
    chk_all_zero("reset");
    rst      = 1'b0;
    man_addr = 5'd5;
    @(negedge clk);
    chk("man_reg_addr", 32'(reg_addr), 32'd5);
    chk("man_valid0", 32'(disp_valid), 32'd0);
    @(negedge clk);
    chk("man_disp_data", disp_data, 32'h1234);
    chk("man_disp_addr", 32'(disp_addr), 32'd5);
    chk("man_valid1", 32'(disp_valid), 32'd0);

    // Full scan: captures every 8 cycles starting 5 cycles after scan_en
    scan_en = 1'b1;
    k = 0;
    for (int c = 1; c <= 37; c++) begin
      cyc();
      chk("scan_active", 32'(scan_active), 32'd1);
      chk("scan_reg_addr", 32'(reg_addr), 32'(((c - 1) / 8) % 4));
      chk("scan_wrap", 32'(wrap), (c == 33) ? 32'd1 : 32'd0);
      if (c >= 5 && ((c - 5) % 8) == 0) begin
        chk("scan_valid", 32'(disp_valid), 32'd1);
        chk("scan_disp_addr", 32'(disp_addr), 32'(((c - 5) / 8) % 4));
        chk("scan_disp_data", disp_data, 32'hA0 + 32'(((c - 5) / 8) % 4));
      end else begin
        chk("scan_valid_idle", 32'(disp_valid), 32'd0);
      end
    end

    // Walk on to register 1's dwell, then hold it for 20 cycles
    for (int c = 38; c <= 44; c++) begin
      cyc();
      chk("pre_hold_addr", 32'(reg_addr), (c <= 40) ? 32'd0 : 32'd1);
    end
    cyc();
    chk("r1_valid", 32'(disp_valid), 32'd1);
    chk("r1_disp_data", disp_data, 32'hA1);
    hold = 1'b1;
    for (int c = 46; c <= 65; c++) begin
      cyc();
      chk("hold_addr", 32'(reg_addr), 32'd1);
      chk("hold_valid", 32'(disp_valid), 32'd0);
    end
    hold = 1'b0;
    for (int c = 66; c <= 68; c++) begin
      cyc();
      chk("rel_addr", 32'(reg_addr), 32'd1);
    end
    cyc();
    chk("rel_adv_addr", 32'(reg_addr), 32'd2);
    chk("rel_adv_wrap", 32'(wrap), 32'd0);
    for (int c = 70; c <= 72; c++) begin
      cyc();
      chk("r2_wait_valid", 32'(disp_valid), 32'd0);
    end
    cyc();
    chk("r2_valid", 32'(disp_valid), 32'd1);
    chk("r2_disp_addr", 32'(disp_addr), 32'd2);
    chk("r2_disp_data", disp_data, 32'hA2);

    // step overrides hold in DWELL; a step in SETUP is ignored
    hold = 1'b1;
    step = 1'b1;
    cyc();
    step = 1'b0;
    chk("step_addr", 32'(reg_addr), 32'd3);
    cyc();
    step = 1'b1;
    cyc();
    step = 1'b0;
    chk("setup_step_addr", 32'(reg_addr), 32'd3);
    cyc();
    chk("step_valid_early", 32'(disp_valid), 32'd0);
    cyc();
    chk("step_valid", 32'(disp_valid), 32'd1);
    chk("step_disp_addr", 32'(disp_addr), 32'd3);
    chk("step_disp_data", disp_data, 32'hA3);
    cyc();
    cyc();
    chk("held_r3_addr", 32'(reg_addr), 32'd3);

    // Reset while dwelling
    rst = 1'b1;
    cyc();
    chk_all_zero("dwell_rst");
    rst  = 1'b0;
    hold = 1'b0;

    // Re-enter scan, then drop scan_en during SETUP
    cyc();
    chk("rescan_active", 32'(scan_active), 32'd1);
    chk("rescan_addr", 32'(reg_addr), 32'd0);
    scan_en  = 1'b0;
    man_addr = 5'd7;
    cyc();
    chk("drop_active", 32'(scan_active), 32'd0);
    chk("drop_reg_addr", 32'(reg_addr), 32'd7);
    chk("drop_valid", 32'(disp_valid), 32'd0);
    cyc();
    chk("drop_disp_addr", 32'(disp_addr), 32'd7);
    chk("drop_disp_data", disp_data, 32'h107);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
